stats_bank: RTL and testbench

STATS_BANK -- requirements
Module: stats_bank

---
 rtl/stats_bank_if.sv | 18 +
 rtl/stats_bank.sv | 78 +++++++
 tb/tb_stats_bank.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/stats_bank_if.sv
// stats_bank_if: bundles the stats_bank data-side signals.
// Signals: inputs (care requests, one bit per channel), random (growth channel select),
//          stats (packed per-channel stats), tick (growth tick pulse), alarm (per-channel flags).
// Modports: master drives inputs/random and observes the rest; slave is the stats_bank side.
interface stats_bank_if #(
    parameter int NCH   = 6,
    parameter int SW    = 4,
    parameter int SEL_W = 5
);
    logic [NCH-1:0]    inputs;
    logic [SEL_W-1:0]  random;
    logic [NCH*SW-1:0] stats;
    logic              tick;
    logic [NCH-1:0]    alarm;

    modport master (output inputs, random, input stats, tick, alarm);
    modport slave  (input inputs, random, output stats, tick, alarm);
endinterface

// File: rtl/stats_bank.sv
// stats_bank: bank of saturating per-channel stats that grow on a prescaled tick and shrink on care edges.
// Ports: clk (rising-edge clock), reset (async active-high), bus (stats_bank_if.slave):
//   bus.inputs level care requests, bus.random growth select (used on tick cycles only),
//   bus.stats packed stats (channel i at [i*SW +: SW]), bus.tick registered tick pulse,
//   bus.alarm registered per-channel (stat >= ALARM_LVL) flags.
// Optional feature: define STATS_ALARM_EN to build the alarm flags; otherwise alarm is tied to 0.
module stats_bank #(
    parameter int NCH       = 6,
    parameter int SW        = 4,
    parameter int TICK_DIV  = 10_000_000,
    parameter int SEL_W     = 5,
    parameter int ALARM_LVL = 12
) (
    input logic       clk,
    input logic       reset,
    stats_bank_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]  pre;
    logic           tick_q;
    logic [NCH-1:0] inputs_q;
    logic [NCH-1:0] rise;
    logic           tick_c;
    logic           grow_ok;

    assign tick_c  = pre == PW'(TICK_DIV - 1);
    assign grow_ok = tick_c && (32'(bus.random) < NCH);
    assign rise    = bus.inputs & ~inputs_q;
    assign bus.tick = tick_q;

    // inputs_q resets to all ones so inputs already high at release are not seen as edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre      <= '0;
            tick_q   <= 1'b0;
            inputs_q <= '1;
        end else begin
            pre      <= tick_c ? '0 : pre + 1'b1;
            tick_q   <= tick_c;
            inputs_q <= bus.inputs;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SW-1:0] st;
        logic          hit;
        logic          up;
        logic          dn;
        assign hit = grow_ok && (32'(bus.random) == i);
        // growth and a decrement in the same cycle cancel, even at the saturation limits
        assign up  = hit & ~rise[i];
        assign dn  = rise[i] & ~hit;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                st <= '0;
            else if (up && st != '1)
                st <= st + 1'b1;
            else if (dn && st != '0)
                st <= st - 1'b1;
        end
        assign bus.stats[i*SW +: SW] = st;
`ifdef STATS_ALARM_EN
        logic al;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                al <= 1'b0;
            else
                al <= st >= SW'(ALARM_LVL);
        end
        assign bus.alarm[i] = al;
`endif
    end

`ifndef STATS_ALARM_EN
    assign bus.alarm = '0;
`endif
endmodule

// File: tb/tb_stats_bank.sv
// tb_stats_bank: directed self-checking bench for stats_bank (NCH=6, SW=4, TICK_DIV=4, ALARM_LVL=12).
// Ports: none; drives the DUT through a stats_bank_if instance. Alarm checks follow STATS_ALARM_EN.
module tb_stats_bank;
    localparam int NCH = 6, SW = 4, TD = 4, SEL_W = 5, ALVL = 12;
`ifdef STATS_ALARM_EN
    localparam bit AL_ON = 1'b1;
`else
    localparam bit AL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stats_bank_if #(.NCH(NCH), .SW(SW), .SEL_W(SEL_W)) bus ();

    stats_bank #(.NCH(NCH), .SW(SW), .TICK_DIV(TD), .SEL_W(SEL_W), .ALARM_LVL(ALVL)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tick !== 1'b1 && n < 20);
        chk("tick_seen", 32'(bus.tick), 32'd1);
    endtask

    task automatic pulse(input logic [5:0] m);
        bus.inputs = m;
        step();
        bus.inputs = '0;
        step();
    endtask

    task automatic grow(input int ch, input int k);
        int n;
        bus.random = SEL_W'(ch);
        repeat (k) wait_tick(n);
        bus.random = 5'd31;
    endtask

    // drive the care edge and select into the cycle where the prescaler reaches TD-1
    task automatic collide(input int ch, input string tag, input logic [3:0] v);
        int n;
        wait_tick(n);
        step();
        step();
        step();
        bus.inputs = 6'(1 << ch);
        bus.random = SEL_W'(ch);
        step();
        chk({tag, "_tick"}, 32'(bus.tick), 32'd1);
        chk(tag, 32'(bus.stats[ch*SW +: SW]), 32'(v));
        bus.inputs = '0;
        bus.random = 5'd31;
        step();
        chk({tag, "_after"}, 32'(bus.stats[ch*SW +: SW]), 32'(v));
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        bus.inputs = '0;
        bus.random = 5'd31;
        step();
        step();
        chk("rst_stats", 32'(bus.stats), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        chk("rst_alarm", 32'(bus.alarm), 32'h0);
        reset = 1'b0;

        bus.random = 5'd2;
        for (int k = 1; k <= 20; k++) begin
            wait_tick(n);
            chk("grow_period", 32'(n), 32'd4);
            chk("grow_stats", 32'(bus.stats), 32'((k < 15 ? k : 15) << 8));
        end
        bus.random = 5'd31;
        step();
        chk("tick_width", 32'(bus.tick), 32'd0);

        grow(0, 5);
        chk("preload", 32'(bus.stats), 32'h000F05);
        repeat (3) pulse(6'b000001);
        chk("care_pulses", 32'(bus.stats), 32'h000F02);
        bus.inputs = 6'b000001;
        repeat (10) step();
        chk("care_held", 32'(bus.stats), 32'h000F01);
        bus.inputs = '0;
        step();
        pulse(6'b000101);
        chk("multi_dec", 32'(bus.stats), 32'h000E00);
        pulse(6'b000001);
        chk("dec_sat0", 32'(bus.stats), 32'h000E00);

        grow(3, 7);
        chk("ch3_7", 32'(bus.stats), 32'h007E00);
        collide(3, "coll7", 4'd7);
        repeat (7) pulse(6'b001000);
        chk("ch3_0", 32'(bus.stats), 32'h000E00);
        collide(3, "coll0", 4'd0);
        grow(3, 15);
        chk("ch3_15", 32'(bus.stats), 32'h00FE00);
        collide(3, "coll15", 4'd15);

        wait_tick(n);
        for (int k = 0; k < 10; k++) begin
            bus.random = (k == 9) ? 5'd31 : 5'(6 + 2 * k);
            wait_tick(n);
            chk("oor_period", 32'(n), 32'd4);
            chk("oor_stats", 32'(bus.stats), 32'h00FE00);
        end
        bus.random = 5'd31;

        chk("alarm_pre", 32'(bus.alarm), AL_ON ? 32'h0C : 32'h0);
        grow(1, 12);
        chk("ch1_12", 32'(bus.stats), 32'h00FEC0);
        chk("alarm_lag", 32'(bus.alarm), AL_ON ? 32'h0C : 32'h0);
        step();
        chk("alarm_set", 32'(bus.alarm), AL_ON ? 32'h0E : 32'h0);
        bus.inputs = 6'b000010;
        step();
        chk("ch1_11", 32'(bus.stats), 32'h00FEB0);
        chk("alarm_hold", 32'(bus.alarm), AL_ON ? 32'h0E : 32'h0);
        bus.inputs = '0;
        step();
        chk("alarm_clr", 32'(bus.alarm), AL_ON ? 32'h0C : 32'h0);

        wait_tick(n);
        step();
        bus.inputs = 6'b111111;
        reset      = 1'b1;
        #1;
        chk("async_stats", 32'(bus.stats), 32'h0);
        chk("async_alarm", 32'(bus.alarm), 32'h0);
        chk("async_tick", 32'(bus.tick), 32'h0);
        step();
        step();
        reset      = 1'b0;
        bus.random = 5'd4;
        wait_tick(n);
        chk("rel_first_tick", 32'(n), 32'd4);
        chk("rel_stats", 32'(bus.stats), 32'h010000);
        bus.random = 5'd31;
        repeat (6) step();
        chk("rel_no_dec", 32'(bus.stats), 32'h010000);
        bus.inputs = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
